// File: rtl/yarp_lsu.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | yarp_lsu : load/store unit, req/gnt/rsp data bus, lane align + extension    |
// | Optional misalignment trap: YARP_LSU_MISALIGN_TRAP_EN      Revision: 1.0    |
// +-----------------------------------------------------------------------------+
module yarp_lsu #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        lsu_req_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [1:0]  lsu_byte_i,
  input  logic        lsu_wr_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic        lsu_zero_extnd_i,
  output logic        lsu_stall_o,
  output logic        lsu_done_o,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_err_o,
  output logic        lsu_misalign_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_wr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int              CNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [1:0]       size_q, size_d;
  logic             wr_q, wr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             zext_q, zext_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             misalign_q, misalign_d;

  logic             misalign_in;
  logic             in_req;
  logic             timeout;
  logic [CNT_W-1:0] cnt_inc;
  logic [3:0]       be;
  logic [31:0]      wdata_rep;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      ld_data;

`ifdef YARP_LSU_MISALIGN_TRAP_EN
  assign misalign_in = ((lsu_byte_i == 2'b01) && lsu_addr_i[0]) ||
                       (lsu_byte_i[1] && (lsu_addr_i[1:0] != 2'b00));
`else
  assign misalign_in = 1'b0;
`endif

  // Saturating count; the cycle that completes the access always takes priority.
  assign cnt_inc = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + 1'b1;
  assign timeout = (cnt_q >= MAX_CNT - 1'b1);
  assign in_req  = (state_q == REQ);

  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata_q;
    case (size_q)
      2'b00: begin
        be        = 4'b0001 << addr_q[1:0];
        wdata_rep = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be        = 4'b0011 << {addr_q[1], 1'b0};
        wdata_rep = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = mem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
    ld_half = mem_rdata_i[{addr_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   ld_data = {{24{ld_byte[7] & ~zext_q}}, ld_byte};
      2'b01:   ld_data = {{16{ld_half[15] & ~zext_q}}, ld_half};
      default: ld_data = mem_rdata_i;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    wr_d       = wr_q;
    wdata_d    = wdata_q;
    zext_d     = zext_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    misalign_d = misalign_q;
    case (state_q)
      IDLE: begin
        if (lsu_req_i) begin
          addr_d     = lsu_addr_i;
          size_d     = lsu_byte_i;
          wr_d       = lsu_wr_i;
          wdata_d    = lsu_wdata_i;
          zext_d     = lsu_zero_extnd_i;
          cnt_d      = '0;
          rdata_d    = '0;
          err_d      = misalign_in;
          misalign_d = misalign_in;
          state_d    = misalign_in ? DONE : REQ;
        end
      end
      REQ: begin
        cnt_d = cnt_inc;
        if (mem_gnt_i) begin
          state_d = RSP;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      RSP: begin
        cnt_d = cnt_inc;
        if (mem_rvalid_i) begin
          rdata_d = ld_data;
          state_d = DONE;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      zext_q     <= 1'b0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      zext_q     <= zext_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      misalign_q <= misalign_d;
    end
  end

  assign lsu_stall_o    = (state_q == IDLE) ? lsu_req_i : (state_q != DONE);
  assign lsu_done_o     = (state_q == DONE);
  assign lsu_rdata_o    = rdata_q;
  assign lsu_err_o      = err_q;
  assign lsu_misalign_o = misalign_q;

  // Bus side is quiet outside REQ so nothing leaks onto it between accesses.
  assign mem_req_o   = in_req;
  assign mem_addr_o  = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_wr_o    = in_req & wr_q;
  assign mem_be_o    = in_req ? be : 4'h0;
  assign mem_wdata_o = in_req ? wdata_rep : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_yarp_lsu.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_yarp_lsu : randomized + directed bench for yarp_lsu (MAX_WAIT = 4)       |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_yarp_lsu;

  localparam int MAXW = 4;
`ifdef YARP_LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        lsu_req_i = 1'b0;
  logic [31:0] lsu_addr_i = '0;
  logic [1:0]  lsu_byte_i = '0;
  logic        lsu_wr_i = 1'b0;
  logic [31:0] lsu_wdata_i = '0;
  logic        lsu_zero_extnd_i = 1'b0;
  logic        lsu_stall_o, lsu_done_o, lsu_err_o, lsu_misalign_o;
  logic [31:0] lsu_rdata_o;
  logic        mem_req_o, mem_wr_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_rdata_i = '0;

  yarp_lsu #(.MAX_WAIT(MAXW)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .lsu_req_i        (lsu_req_i),
    .lsu_addr_i       (lsu_addr_i),
    .lsu_byte_i       (lsu_byte_i),
    .lsu_wr_i         (lsu_wr_i),
    .lsu_wdata_i      (lsu_wdata_i),
    .lsu_zero_extnd_i (lsu_zero_extnd_i),
    .lsu_stall_o      (lsu_stall_o),
    .lsu_done_o       (lsu_done_o),
    .lsu_rdata_o      (lsu_rdata_o),
    .lsu_err_o        (lsu_err_o),
    .lsu_misalign_o   (lsu_misalign_o),
    .mem_req_o        (mem_req_o),
    .mem_gnt_i        (mem_gnt_i),
    .mem_addr_o       (mem_addr_o),
    .mem_wr_o         (mem_wr_o),
    .mem_be_o         (mem_be_o),
    .mem_wdata_o      (mem_wdata_o),
    .mem_rvalid_i     (mem_rvalid_i),
    .mem_rdata_i      (mem_rdata_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected view of the access in flight, filled in by the model.
  bit          chk_en = 1'b0;
  bit          txn_active = 1'b0;
  int          e_t0, e_done, e_req_lo, e_req_hi;
  logic [31:0] e_addr, e_wdata, e_rdata;
  logic [3:0]  e_be;
  logic        e_wr, e_err, e_mis;
  logic [31:0] hold_rdata = '0;
  logic        hold_err = 1'b0, hold_mis = 1'b0;

  // Observations kept for the literal checks of directed cases.
  logic [31:0] cap_addr, cap_wdata, cap_rdata;
  logic [3:0]  cap_be;
  logic        cap_wr, cap_err, cap_mis;
  int          cap_done_cyc, cap_req_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial begin : compare
    bit in_req;
    forever begin
      @(negedge clk);
      #1;
      if (!chk_en || !reset_n) continue;
      if (txn_active) begin
        in_req = (cyc >= e_req_lo) && (cyc <= e_req_hi);
        chk("stall", lsu_stall_o, cyc < e_done);
        chk("done", lsu_done_o, cyc == e_done);
        chk("mem_req", mem_req_o, in_req);
        if (mem_req_o) begin
          cap_req_cnt++;
          cap_addr = mem_addr_o; cap_be = mem_be_o; cap_wr = mem_wr_o; cap_wdata = mem_wdata_o;
        end
        if (in_req) begin
          chk("mem_addr", mem_addr_o, e_addr);
          chk("mem_be", mem_be_o, e_be);
          chk("mem_wr", mem_wr_o, e_wr);
          chk("mem_wdata", mem_wdata_o, e_wdata);
        end
        if (lsu_done_o) begin
          cap_done_cyc = cyc;
          cap_rdata = lsu_rdata_o; cap_err = lsu_err_o; cap_mis = lsu_misalign_o;
        end
        if (cyc == e_done) begin
          chk("rdata", lsu_rdata_o, e_rdata);
          chk("err", lsu_err_o, e_err);
          chk("misalign", lsu_misalign_o, e_mis);
        end
        if (cyc == e_t0) begin
          chk("hold_rdata_t0", lsu_rdata_o, hold_rdata);
          chk("hold_err_t0", lsu_err_o, hold_err);
        end
      end else begin
        chk("idle_stall", lsu_stall_o, lsu_req_i);
        chk("idle_done", lsu_done_o, 1'b0);
        chk("idle_mem_req", mem_req_o, 1'b0);
        chk("hold_rdata", lsu_rdata_o, hold_rdata);
        chk("hold_err", lsu_err_o, hold_err);
        chk("hold_mis", lsu_misalign_o, hold_mis);
      end
    end
  end

  // One access from request to the idle cycle after DONE; g<0 means never grant.
  // Called at a negedge; returns at the negedge of the cycle after DONE.
  task automatic run_txn(input logic [31:0] a, input logic [1:0] sz, input logic w,
                         input logic [31:0] wd, input logic zx, input int g, input int r,
                         input logic [31:0] rw, input logic late);
    int k_gnt, k_rv, done_k, req_n, phase;
    logic mis, abort;
    logic [31:0] lane, ext;
    k_gnt  = (g < 0) ? 1000 : g + 1;
    k_rv   = k_gnt + 1 + r;
    mis    = TRAP && (((sz == 2'b01) && a[0]) || (sz[1] && (a[1:0] != 2'b00)));
    abort  = 1'b0;
    done_k = 0;
    req_n  = 0;
    if (mis) begin
      done_k = 1;
    end else begin
      phase = 1;
      for (int k = 1; k < 1000 && done_k == 0; k++) begin
        if (phase == 1) begin
          if (k == k_gnt) begin phase = 2; req_n = k; end
          else if (k >= MAXW) begin abort = 1'b1; req_n = k; done_k = k + 1; end
        end else if (k == k_rv) begin
          done_k = k + 1;
        end else if (k >= MAXW) begin
          abort = 1'b1; done_k = k + 1;
        end
      end
    end
    case (sz)
      2'b00: begin
        lane    = (rw >> (8 * a[1:0])) & 32'hFF;
        ext     = (!zx && lane[7]) ? (lane | 32'hFFFFFF00) : lane;
        e_be    = 4'(1 << a[1:0]);
        e_wdata = (wd & 32'hFF) * 32'h01010101;
      end
      2'b01: begin
        lane    = a[1] ? (rw >> 16) : (rw & 32'hFFFF);
        ext     = (!zx && lane[15]) ? (lane | 32'hFFFF0000) : lane;
        e_be    = a[1] ? 4'b1100 : 4'b0011;
        e_wdata = (wd & 32'hFFFF) * 32'h00010001;
      end
      default: begin
        ext     = rw;
        e_be    = 4'b1111;
        e_wdata = wd;
      end
    endcase
    e_t0     = cyc;
    e_done   = cyc + done_k;
    e_req_lo = cyc + 1;
    e_req_hi = cyc + req_n;
    e_addr   = {a[31:2], 2'b00};
    e_wr     = w;
    e_err    = mis || abort;
    e_mis    = mis;
    e_rdata  = (mis || abort) ? 32'h0 : ext;
    cap_req_cnt  = 0;
    cap_done_cyc = -1;
    lsu_req_i = 1'b1; lsu_addr_i = a; lsu_byte_i = sz; lsu_wr_i = w;
    lsu_wdata_i = wd; lsu_zero_extnd_i = zx;
    txn_active = 1'b1;
    for (int k = 1; k <= done_k; k++) begin
      @(negedge clk);
      mem_gnt_i    = (k == k_gnt);
      mem_rvalid_i = (k == k_rv) || (late && k == done_k);
      mem_rdata_i  = (k == k_rv) ? rw : $urandom;
      if (k == done_k) begin
        lsu_req_i   = 1'($urandom);
        lsu_addr_i  = $urandom;
        lsu_byte_i  = 2'($urandom);
        lsu_wdata_i = $urandom;
      end
    end
    @(negedge clk);
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = late;
    mem_rdata_i  = $urandom;
    lsu_req_i    = 1'b0;
    txn_active   = 1'b0;
    hold_rdata   = e_rdata;
    hold_err     = e_err;
    hold_mis     = e_mis;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin : stim
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #2;
    chk("rst_stall", lsu_stall_o, 1'b0);
    chk("rst_done", lsu_done_o, 1'b0);
    chk("rst_rdata", lsu_rdata_o, 32'h0);
    chk("rst_mem_req", mem_req_o, 1'b0);
    chk("rst_mem_be", mem_be_o, 4'h0);
    chk_en = 1'b1;
    @(negedge clk);

    // Signed byte load from the top lane, zero-wait bus.
    run_txn(32'h103, 2'b00, 1'b0, 32'h0, 1'b0, 0, 0, 32'hA5000000, 1'b0);
    chk("t1_addr", cap_addr, 32'h100);
    chk("t1_be", cap_be, 4'b1000);
    chk("t1_rdata", cap_rdata, 32'hFFFFFFA5);
    chk("t1_latency", cap_done_cyc - e_t0, 3);

    // Half store with grant on the last allowed REQ cycle.
    run_txn(32'h202, 2'b01, 1'b1, 32'h0000BEEF, 1'b0, 3, 0, 32'h0, 1'b0);
    chk("t2_be", cap_be, 4'b1100);
    chk("t2_wdata", cap_wdata, 32'hBEEFBEEF);
    chk("t2_wr", cap_wr, 1'b1);
    chk("t2_err", cap_err, 1'b0);
    chk("t2_req_cycles", cap_req_cnt, 4);

    // Grant never comes: abort after MAXW REQ cycles, late rvalid ignored.
    run_txn(32'h300, 2'b11, 1'b0, 32'h0, 1'b0, -1, 0, 32'h0, 1'b1);
    chk("t3_latency", cap_done_cyc - e_t0, MAXW + 1);
    chk("t3_err", cap_err, 1'b1);
    chk("t3_req_cycles", cap_req_cnt, MAXW);
    repeat (2) @(negedge clk);
    mem_rvalid_i = 1'b0;

    // Misaligned word load.
    run_txn(32'h102, 2'b11, 1'b0, 32'h0, 1'b0, 0, 0, 32'h12345678, 1'b0);
`ifdef YARP_LSU_MISALIGN_TRAP_EN
    chk("t4_latency", cap_done_cyc - e_t0, 1);
    chk("t4_err", cap_err, 1'b1);
    chk("t4_mis", cap_mis, 1'b1);
    chk("t4_no_req", cap_req_cnt, 0);
`else
    chk("t4_addr", cap_addr, 32'h100);
    chk("t4_be", cap_be, 4'b1111);
    chk("t4_rdata", cap_rdata, 32'h12345678);
`endif

    // Reset while waiting for the response.
    chk_en = 1'b0;
    lsu_req_i = 1'b1; lsu_addr_i = 32'h40; lsu_byte_i = 2'b11; lsu_wr_i = 1'b1;
    lsu_wdata_i = 32'hCAFEF00D;
    @(negedge clk);
    mem_gnt_i = 1'b1;
    @(negedge clk);
    mem_gnt_i = 1'b0;
    #2;
    chk("t5_rsp_stall", lsu_stall_o, 1'b1);
    @(negedge clk);
    reset_n = 1'b0; lsu_req_i = 1'b0;
    @(negedge clk);
    reset_n = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFFFFFF;
    #2;
    chk("t5_stall", lsu_stall_o, 1'b0);
    chk("t5_done", lsu_done_o, 1'b0);
    chk("t5_mem_req", mem_req_o, 1'b0);
    chk("t5_mem_addr", mem_addr_o, 32'h0);
    chk("t5_mem_wr", mem_wr_o, 1'b0);
    chk("t5_mem_wdata", mem_wdata_o, 32'h0);
    chk("t5_err", lsu_err_o, 1'b0);
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    #2;
    chk("t5_done_after", lsu_done_o, 1'b0);
    chk("t5_rdata_after", lsu_rdata_o, 32'h0);
    hold_rdata = '0; hold_err = 1'b0; hold_mis = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    run_txn(32'h42, 2'b01, 1'b0, 32'h0, 1'b1, 1, 1, 32'h80011234, 1'b0);
    chk("t5_fresh_rdata", cap_rdata, 32'h00008001);
    chk("t5_fresh_err", cap_err, 1'b0);

    // Randomized traffic, including REQ and RSP timeouts.
    for (int i = 0; i < 150; i++) begin
      int g;
      g = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
      run_txn($urandom, 2'($urandom), 1'($urandom), $urandom, 1'($urandom),
              g, int'($urandom_range(0, 2)), $urandom, 1'($urandom_range(0, 3) == 0));
      mem_rvalid_i = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
